// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and register-index helper
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int CTRL_W     = 16;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // One-hot of a register index; x0 maps to all-zero so it can never be tracked
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        reg_onehot = '0;
        if (r != '0) begin
            reg_onehot[r] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/operand_fetch_stage_scoreboard.sv
// rtl/operand_fetch_stage_scoreboard.sv - pending-write busy vector with hazard query
module operand_fetch_stage_scoreboard
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_set_en,
    input  logic [REG_ADDR_W-1:0] i_set_rd,
    input  logic                  i_wb_clr_en,
    input  logic [REG_ADDR_W-1:0] i_wb_clr_rd,
    input  logic                  i_fl_clr_en,
    input  logic [REG_ADDR_W-1:0] i_fl_clr_rd,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic                  i_rd_wen,
    output logic                  o_hazard,
    output logic [NUM_REGS-1:0]   o_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_wb_clr;
    logic [NUM_REGS-1:0] w_fl_clr;
    logic [NUM_REGS-1:0] w_pending;

    assign w_set    = i_set_en    ? reg_onehot(i_set_rd)    : '0;
    assign w_wb_clr = i_wb_clr_en ? reg_onehot(i_wb_clr_rd) : '0;
    assign w_fl_clr = i_fl_clr_en ? reg_onehot(i_fl_clr_rd) : '0;

    // A writer retiring this cycle no longer blocks; bit 0 is never set so x0 is masked
    assign w_pending = r_busy & ~w_wb_clr;
    assign o_hazard  = w_pending[i_rs1] | w_pending[i_rs2] | (i_rd_wen & w_pending[i_rd]);
    assign o_busy    = r_busy;

    // Busy vector update: clears first, then a new issue's set takes priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_wb_clr & ~w_fl_clr) | w_set;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - decode-to-execute operand fetch with bypass and hazard stall
module operand_fetch_stage #(
    parameter int XLEN   = cpu_pkg::XLEN,
    parameter int CTRL_W = cpu_pkg::CTRL_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] in_rs1,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] in_rs2,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] in_rd,
    input  logic                          in_rd_wen,
    input  logic [XLEN-1:0]               in_imm,
    input  logic [CTRL_W-1:0]             in_ctrl,
    output logic [cpu_pkg::REG_ADDR_W-1:0] rf_read_reg1,
    output logic [cpu_pkg::REG_ADDR_W-1:0] rf_read_reg2,
    input  logic [XLEN-1:0]               rf_read_data1,
    input  logic [XLEN-1:0]               rf_read_data2,
    input  logic                          wb_valid,
    input  logic                          wb_wen,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]               wb_data,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               out_op_a,
    output logic [XLEN-1:0]               out_op_b,
    output logic [XLEN-1:0]               out_imm,
    output logic [CTRL_W-1:0]             out_ctrl,
    output logic [cpu_pkg::REG_ADDR_W-1:0] out_rd,
    output logic                          out_rd_wen
);

    logic                           r_out_valid;
    logic [XLEN-1:0]                r_out_op_a;
    logic [XLEN-1:0]                r_out_op_b;
    logic [XLEN-1:0]                r_out_imm;
    logic [CTRL_W-1:0]              r_out_ctrl;
    logic [cpu_pkg::REG_ADDR_W-1:0] r_out_rd;
    logic                           r_out_rd_wen;

    logic            w_hazard;
    logic            w_space;
    logic            w_issue;
    logic            w_fl_clr_en;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [cpu_pkg::NUM_REGS-1:0] w_busy;

    assign rf_read_reg1 = in_rs1;
    assign rf_read_reg2 = in_rs2;

    assign w_space  = !r_out_valid || out_ready;
    assign in_ready = w_space && !w_hazard && !flush;
    assign w_issue  = in_valid && in_ready;

    // A flushed writer will never return a writeback, so release its busy bit here
    assign w_fl_clr_en = flush && r_out_valid && r_out_rd_wen;

    operand_fetch_stage_scoreboard u_sb (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_set_en    (w_issue && in_rd_wen),
        .i_set_rd    (in_rd),
        .i_wb_clr_en (wb_valid),
        .i_wb_clr_rd (wb_rd),
        .i_fl_clr_en (w_fl_clr_en),
        .i_fl_clr_rd (r_out_rd),
        .i_rs1       (in_rs1),
        .i_rs2       (in_rs2),
        .i_rd        (in_rd),
        .i_rd_wen    (in_rd_wen),
        .o_hazard    (w_hazard),
        .o_busy      (w_busy)
    );

    // Operand bypass: x0 is zero, same-cycle writeback beats the stale register-file value
    always_comb begin
        w_op_a = rf_read_data1;
        w_op_b = rf_read_data2;
        if (in_rs1 == '0) begin
            w_op_a = '0;
        end else if (wb_valid && wb_wen && (wb_rd == in_rs1)) begin
            w_op_a = wb_data;
        end
        if (in_rs2 == '0) begin
            w_op_b = '0;
        end else if (wb_valid && wb_wen && (wb_rd == in_rs2)) begin
            w_op_b = wb_data;
        end
    end

    // Output register: load on issue, drop on flush or consume, otherwise hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_op_a   <= '0;
            r_out_op_b   <= '0;
            r_out_imm    <= '0;
            r_out_ctrl   <= '0;
            r_out_rd     <= '0;
            r_out_rd_wen <= 1'b0;
        end else if (w_issue) begin
            r_out_valid  <= 1'b1;
            r_out_op_a   <= w_op_a;
            r_out_op_b   <= w_op_b;
            r_out_imm    <= in_imm;
            r_out_ctrl   <= in_ctrl;
            r_out_rd     <= in_rd;
            r_out_rd_wen <= in_rd_wen;
        end else if (flush || out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_op_a   = r_out_op_a;
    assign out_op_b   = r_out_op_b;
    assign out_imm    = r_out_imm;
    assign out_ctrl   = r_out_ctrl;
    assign out_rd     = r_out_rd;
    assign out_rd_wen = r_out_rd_wen;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - directed self-checking bench for operand_fetch_stage
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_rd_wen;
    logic [31:0] in_imm;
    logic [15:0] in_ctrl;
    logic [4:0]  rf_read_reg1, rf_read_reg2;
    logic [31:0] rf_read_data1, rf_read_data2;
    logic        wb_valid, wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_op_a, out_op_b, out_imm;
    logic [15:0] out_ctrl;
    logic [4:0]  out_rd;
    logic        out_rd_wen;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .in_imm(in_imm), .in_ctrl(in_ctrl),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op_a(out_op_a), .out_op_b(out_op_b), .out_imm(out_imm),
        .out_ctrl(out_ctrl), .out_rd(out_rd), .out_rd_wen(out_rd_wen)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic wen, input logic [31:0] d1, input logic [31:0] d2);
        in_valid      = 1'b1;
        in_rs1        = rs1;
        in_rs2        = rs2;
        in_rd         = rd;
        in_rd_wen     = wen;
        rf_read_data1 = d1;
        rf_read_data2 = d2;
        #1;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid = v;
        wb_wen   = v;
        wb_rd    = rd;
        wb_data  = d;
        #1;
    endtask

    // Writeback contract: a retiring register must currently be tracked as busy
    always @(negedge clk) begin
        if (reset_n && wb_valid && wb_rd != 5'd0)
            chk("wb_to_busy_reg", 64'(dut.u_sb.r_busy[wb_rd]), 64'd1);
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_wen = 1'b0;
        in_imm = '0; in_ctrl = '0; rf_read_data1 = '0; rf_read_data2 = '0;
        wb_valid = 1'b0; wb_wen = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
        step(); step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_op_a", 64'(out_op_a), 64'd0);
        chk("rst_busy", 64'(dut.u_sb.r_busy), 64'd0);
        reset_n = 1'b1;
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Back-to-back RAW with writeback bypass
        instr(5'd1, 5'd2, 5'd3, 1'b1, 32'h11, 32'h22);
        chk("raw_first_ready", 64'(in_ready), 64'd1);
        step();
        chk("raw_first_op_a", 64'(out_op_a), 64'h11);
        chk("raw_first_op_b", 64'(out_op_b), 64'h22);
        chk("raw_busy3", 64'(dut.u_sb.r_busy[3]), 64'd1);
        instr(5'd3, 5'd0, 5'd4, 1'b1, 32'hDEAD, 32'h5);
        chk("raw_stall0", 64'(in_ready), 64'd0);
        step();
        chk("raw_stall1", 64'(in_ready), 64'd0);
        chk("raw_bubble", 64'(out_valid), 64'd0);
        wb(1'b1, 5'd3, 32'hAA);
        chk("raw_ready_on_wb", 64'(in_ready), 64'd1);
        step();
        wb(1'b0, 5'd0, 32'h0);
        in_valid = 1'b0;
        chk("raw_bypass_op_a", 64'(out_op_a), 64'hAA);
        chk("raw_op_b_x0", 64'(out_op_b), 64'd0);
        chk("raw_out_rd", 64'(out_rd), 64'd4);
        chk("raw_busy_after", 64'(dut.u_sb.r_busy), 64'h10);
        wb(1'b1, 5'd4, 32'h1);
        step();
        wb(1'b0, 5'd0, 32'h0);
        chk("raw_busy_clear", 64'(dut.u_sb.r_busy), 64'd0);

        // x0 source and destination
        instr(5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("x0_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("x0_op_a", 64'(out_op_a), 64'd0);
        chk("x0_busy", 64'(dut.u_sb.r_busy), 64'd0);

        // Backpressure hold and no-bubble reload
        in_imm = 32'h1234; in_ctrl = 16'hBEEF;
        instr(5'd1, 5'd2, 5'd0, 1'b0, 32'h55, 32'h66);
        step();
        chk("bp_load_a", 64'(out_op_a), 64'h55);
        out_ready = 1'b0;
        in_imm = 32'h9999; in_ctrl = 16'h0101;
        instr(5'd1, 5'd2, 5'd0, 1'b0, 32'h77, 32'h88);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            step();
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_a", 64'(out_op_a), 64'h55);
            chk("bp_hold_imm", 64'(out_imm), 64'h1234);
            chk("bp_hold_ctrl", 64'(out_ctrl), 64'hBEEF);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp_new_valid", 64'(out_valid), 64'd1);
        chk("bp_new_a", 64'(out_op_a), 64'h77);
        chk("bp_new_imm", 64'(out_imm), 64'h9999);
        step();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // WAW stall resolved by same-cycle writeback
        instr(5'd0, 5'd0, 5'd5, 1'b1, 32'h0, 32'h0);
        step();
        chk("waw_busy5", 64'(dut.u_sb.r_busy[5]), 64'd1);
        chk("waw_stall0", 64'(in_ready), 64'd0);
        step();
        chk("waw_stall1", 64'(in_ready), 64'd0);
        wb(1'b1, 5'd5, 32'h5);
        chk("waw_ready_on_wb", 64'(in_ready), 64'd1);
        step();
        wb(1'b0, 5'd0, 32'h0);
        in_valid = 1'b0;
        chk("waw_set_wins", 64'(dut.u_sb.r_busy[5]), 64'd1);
        chk("waw_out_rd", 64'(out_rd), 64'd5);
        wb(1'b1, 5'd5, 32'h6);
        step();
        wb(1'b0, 5'd0, 32'h0);
        chk("waw_clear", 64'(dut.u_sb.r_busy), 64'd0);

        // Flush of a held writer releases its busy bit
        instr(5'd0, 5'd0, 5'd7, 1'b1, 32'h0, 32'h0);
        step();
        out_ready = 1'b0;
        chk("fl_busy7", 64'(dut.u_sb.r_busy[7]), 64'd1);
        flush = 1'b1;
        instr(5'd7, 5'd0, 5'd8, 1'b1, 32'h700, 32'h0);
        chk("fl_no_issue", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0;
        #1;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_busy7_clr", 64'(dut.u_sb.r_busy[7]), 64'd0);
        chk("fl_dep_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("fl_dep_op_a", 64'(out_op_a), 64'h700);
        chk("fl_dep_rd", 64'(out_rd), 64'd8);
        out_ready = 1'b1;
        wb(1'b1, 5'd8, 32'h8);
        step();
        wb(1'b0, 5'd0, 32'h0);
        chk("fl_final_busy", 64'(dut.u_sb.r_busy), 64'd0);

        // Asynchronous reset in the middle of a held writer
        out_ready = 1'b0;
        instr(5'd1, 5'd2, 5'd9, 1'b1, 32'h99, 32'h98);
        step();
        in_valid = 1'b0;
        chk("mr_busy9", 64'(dut.u_sb.r_busy[9]), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_busy", 64'(dut.u_sb.r_busy), 64'd0);
        chk("mr_op_a", 64'(out_op_a), 64'd0);
        step();
        reset_n = 1'b1;
        #1;
        chk("mr_in_ready", 64'(in_ready), 64'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
